// File: rtl/packet_arbiter_mux.sv
// Packet-aware N-to-1 egress multiplexer: round-robin arbitration among ingress streams,
// grant held from first beat to end-of-packet, registered egress stage.
module packet_arbiter_mux #(
   parameter int unsigned N_PORTS    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_WIDTH  = $clog2(N_PORTS)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   ingress_data,
   input  logic [N_PORTS-1:0]                   ingress_valid,
   input  logic [N_PORTS-1:0]                   ingress_eop,
   output logic [N_PORTS-1:0]                   ingress_ready,
   output logic [DATA_WIDTH-1:0]                egress_data,
   output logic                                 egress_valid,
   output logic                                 egress_eop,
   input  logic                                 egress_ready,
   output logic [IDX_WIDTH-1:0]                 selected_ingress,
   output logic                                 locked,
   output logic [31:0]                          pkt_count
);

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e               state;
   logic [IDX_WIDTH-1:0] last_grant;
   logic [IDX_WIDTH-1:0] rr_cand;
   logic [IDX_WIDTH-1:0] rr_winner;
   logic                 rr_any;
   logic                 in_xfer;
   logic                 in_eop;
   logic                 out_xfer;

   // Walk the ring from the far end back towards last_grant+1 so the nearest valid port wins.
   always_comb begin
      rr_cand   = '0;
      rr_winner = '0;
      rr_any    = 1'b0;
      for (int i = int'(N_PORTS); i >= 1; i--) begin
         rr_cand = IDX_WIDTH'((int'(last_grant) + i) % int'(N_PORTS));
         if (ingress_valid[rr_cand]) begin
            rr_winner = rr_cand;
            rr_any    = 1'b1;
         end
      end
   end

   // Only the granted port may see ready, and only when the output register has room.
   always_comb begin
      ingress_ready = '0;
      if (state == StLocked) begin
         ingress_ready[selected_ingress] = !egress_valid || egress_ready;
      end
   end

   assign in_xfer  = |(ingress_valid & ingress_ready);
   assign in_eop   = ingress_eop[selected_ingress];
   assign out_xfer = egress_valid && egress_ready;
   assign locked   = (state == StLocked);

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= StIdle;
         selected_ingress <= '0;
         last_grant       <= IDX_WIDTH'(N_PORTS - 1);
      end else begin
         unique case (state)
            StIdle: begin
               if (rr_any) begin
                  selected_ingress <= rr_winner;
                  state            <= StLocked;
               end
            end
            StLocked: begin
               if (in_xfer && in_eop) begin
                  last_grant <= selected_ingress;
                  state      <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         egress_data  <= '0;
         egress_eop   <= 1'b0;
         egress_valid <= 1'b0;
      end else if (in_xfer) begin
         egress_data  <= ingress_data[selected_ingress];
         egress_eop   <= in_eop;
         egress_valid <= 1'b1;
      end else if (egress_ready) begin
         egress_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count <= '0;
      end else if (out_xfer && egress_eop) begin
         pkt_count <= pkt_count + 32'd1;
      end
   end

endmodule
